// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the lane/legality helpers used when a request is captured.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Width code must exist for the direction and the address must be
    // naturally aligned for that width.
    function automatic logic access_legal(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic width_ok;
        logic align_ok;
        if (we) begin
            width_ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
        end else begin
            width_ok = (f3 == LB) || (f3 == LH) || (f3 == LW) ||
                       (f3 == LBU) || (f3 == LHU);
        end
        case (f3[1:0])
            2'b01:   align_ok = ~lo[0];
            2'b10:   align_ok = (lo == 2'b00);
            default: align_ok = 1'b1;
        endcase
        return width_ok && align_ok;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                                input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3[1:0])
            2'b00:   lanes = {4{wd[7:0]}};
            2'b01:   lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed lane from a bus word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'd0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between an RV32I core and a req/gnt/rvalid
// bus; the request is captured in IDLE and replayed from registers thereafter.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_en,
    input  logic                  mem_we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  stall,
    output logic                  err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    lsu_state_e            state_q, state_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  legal;
    logic [DATA_WIDTH-1:0] load_fmt;

    lsu_load_align u_load_align (
        .rdata   (bus_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .data    (load_fmt)
    );

    assign legal = access_legal(mem_we, funct3, addr[1:0]);

    // Core inputs only matter in IDLE; REQ/WAIT stall unconditionally because
    // the captured request, not the live instruction, owns the bus.
    always_comb begin
        stall = 1'b0;
        err   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = mem_en && legal;
                err   = mem_en && !legal;
            end
            REQ, WAIT: stall = 1'b1;
            default:   stall = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        ld_data_d   = ld_data_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        case (state_q)
            IDLE: begin
                if (mem_en && legal) begin
                    state_d     = REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                    bus_be_d    = lane_be(funct3, addr[1:0]);
                    bus_wdata_d = mem_we ? store_lanes(funct3, wdata) : '0;
                    funct3_d    = funct3;
                    addr_lo_d   = addr[1:0];
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    if (bus_we_q) begin
                        state_d = DONE;
                    end else if (bus_rvalid) begin
                        ld_data_d = load_fmt;
                        state_d   = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    ld_data_d = load_fmt;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            ld_data_q   <= '0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            ld_data_q   <= ld_data_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses against a behavioural model of lane/format/legality rules.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ld_data;
    logic        stall;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_ld = '0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .ld_data    (ld_data),
        .stall      (stall),
        .err        (err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned size;
        bit          code_ok;
        if (we) code_ok = (f3 <= 3'd2);
        else    code_ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = 1 << f3[1:0];
        return code_ok && ((a % size) == 0);
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned size;
        int unsigned off;
        size = 1 << f3[1:0];
        off  = (a % 4) / size * size;
        return 32'(((1 << size) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int unsigned bits;
        logic [31:0] v;
        if (f3[1:0] == 2'd2) return rd;
        bits = 8 << f3[1:0];
        v = (rd >> (((a % 4) / (bits / 8)) * bits)) & ((32'd1 << bits) - 1);
        if (f3[2] == 1'b0 && v[bits-1]) v = v | ~((32'd1 << bits) - 1);
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic scramble_core();
        mem_en = 1'b1;
        mem_we = 1'($urandom);
        funct3 = 3'($urandom);
        addr   = $urandom;
        wdata  = $urandom;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        mem_en     = 1'b0;
        mem_we     = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        wdata      = $urandom;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'($urandom);
        bus_rdata  = $urandom;
        #1;
        check("idle_stall", 32'(stall), 0);
        check("idle_err", 32'(err), 0);
        check("idle_req", 32'(bus_req), 0);
        check("idle_ld_hold", ld_data, exp_ld);
    endtask

    // gnt comes in REQ cycle gnt_dly+1; rv_dly=0 means rvalid with gnt,
    // otherwise rvalid in WAIT cycle rv_dly.
    task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                              input logic [31:0] rd);
        int stall_cycles;
        int exp_cycles;
        logic [31:0] e_addr;
        logic [31:0] e_be;
        logic [31:0] e_wd;
        e_addr = {a[31:2], 2'b00};
        e_be   = model_be(f3, a);
        e_wd   = model_wdata(f3, wd);
        exp_cycles = 2 + gnt_dly + ((!we && rv_dly > 0) ? rv_dly : 0);
        stall_cycles = 0;

        @(negedge clk);
        mem_en = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
        #1;
        check("detect_err", 32'(err), 0);
        check("detect_req", 32'(bus_req), 0);
        if (stall) stall_cycles++;

        for (int k = 0; k <= gnt_dly; k++) begin
            @(negedge clk);
            scramble_core();
            bus_gnt    = (k == gnt_dly);
            bus_rvalid = (k == gnt_dly) && !we && (rv_dly == 0);
            bus_rdata  = bus_rvalid ? rd : $urandom;
            #1;
            check("req_req", 32'(bus_req), 1);
            check("req_we", 32'(bus_we), 32'(we));
            check("req_addr", bus_addr, e_addr);
            check("req_be", 32'(bus_be), e_be);
            if (we) check("req_wdata", bus_wdata, e_wd);
            check("req_err", 32'(err), 0);
            if (stall) stall_cycles++;
        end

        if (!we && rv_dly > 0) begin
            for (int k = 1; k <= rv_dly; k++) begin
                @(negedge clk);
                scramble_core();
                bus_gnt    = 1'b0;
                bus_rvalid = (k == rv_dly);
                bus_rdata  = bus_rvalid ? rd : $urandom;
                #1;
                check("wait_req", 32'(bus_req), 0);
                if (stall) stall_cycles++;
            end
        end

        if (!we) exp_ld = model_load(f3, a, rd);
        @(negedge clk);
        scramble_core();
        bus_gnt = 1'b0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
        #1;
        check("done_stall", 32'(stall), 0);
        check("done_req", 32'(bus_req), 0);
        check("done_ld", ld_data, exp_ld);
        check("stall_cycles", 32'(stall_cycles), 32'(exp_cycles));
        bus_rvalid = 1'b0;
    endtask

    task automatic run_illegal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        @(negedge clk);
        mem_en = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = $urandom;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        check("ill_err", 32'(err), 1);
        check("ill_stall", 32'(stall), 0);
        check("ill_req", 32'(bus_req), 0);
        @(negedge clk);
        #1;
        check("ill_err_hold", 32'(err), 1);
        check("ill_req_hold", 32'(bus_req), 0);
        check("ill_ld_hold", ld_data, exp_ld);
    endtask

    initial begin
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;

        rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        #2;
        check("rst_req", 32'(bus_req), 0);
        check("rst_we", 32'(bus_we), 0);
        check("rst_addr", bus_addr, 0);
        check("rst_be", 32'(bus_be), 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_ld", ld_data, 0);
        check("rst_stall", 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // SW with gnt in the second REQ cycle
        run_access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1, 0, '0);
        idle_cycle();

        // LB / LBU on the top lane
        run_access(1'b0, 3'b000, 32'h203, '0, 0, 2, 32'h80FF_FF7F);
        check("lb_value", ld_data, 32'hFFFF_FF80);
        idle_cycle();
        run_access(1'b0, 3'b100, 32'h203, '0, 1, 1, 32'h80FF_FF7F);
        check("lbu_value", ld_data, 32'h0000_0080);
        idle_cycle();

        // LH with gnt and rvalid together
        run_access(1'b0, 3'b001, 32'h302, '0, 0, 0, 32'h8001_1234);
        check("lh_value", ld_data, 32'hFFFF_8001);
        idle_cycle();

        // misaligned word load
        run_illegal(1'b0, 3'b010, 32'h101);
        idle_cycle();

        // back-to-back SH then LW
        run_access(1'b1, 3'b001, 32'h402, 32'h0000_ABCD, 0, 0, '0);
        check("sh_be", 32'(bus_be), 32'hC);
        check("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        run_access(1'b0, 3'b010, 32'h404, '0, 2, 1, 32'h1357_9BDF);
        check("lw_value", ld_data, 32'h1357_9BDF);
        idle_cycle();

        // reset while waiting for read data
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        check("pre_rst_wait_stall", 32'(stall), 1);
        #2;
        rst = 1'b1; mem_en = 1'b0;
        #1;
        exp_ld = '0;
        check("midrst_req", 32'(bus_req), 0);
        check("midrst_ld", ld_data, 0);
        check("midrst_stall", 32'(stall), 0);
        check("midrst_addr", bus_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        check("late_rvalid_ld", ld_data, 0);
        check("late_rvalid_req", 32'(bus_req), 0);
        check("late_rvalid_stall", 32'(stall), 0);
        run_access(1'b1, 3'b000, 32'h601, 32'h0000_005A, 0, 0, '0);
        idle_cycle();

        // randomized accesses
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
            if (model_legal(we, f3, a))
                run_access(we, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            else
                run_illegal(we, f3, a);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
